// File: rtl/srrc_tx_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// srrc_tx_sequencer_pkg
// Shared constants for the SRRC transmit sequencer and its clock-enable
// divider: 4-ASK symbol codes, sequencer state encoding and default rates.
// No ports (package).
// -----------------------------------------------------------------------------
package srrc_tx_sequencer_pkg;

    localparam int SYM_W = 18;

    // 4-ASK levels in s0.17: +0.75, +0.25, -0.25, -0.75
    localparam logic [SYM_W-1:0] SYMBOL_P2 = 18'h18000;
    localparam logic [SYM_W-1:0] SYMBOL_P1 = 18'h08000;
    localparam logic [SYM_W-1:0] SYMBOL_N1 = 18'h38000;
    localparam logic [SYM_W-1:0] SYMBOL_N2 = 18'h28000;

    typedef enum logic [1:0] {
        TXSEQ_IDLE  = 2'd0,
        TXSEQ_RUN   = 2'd1,
        TXSEQ_FLUSH = 2'd2
    } txseq_state_e;

    localparam int CLKS_PER_SAM_DEF = 4;
    localparam int SAMS_PER_SYM_DEF = 4;
    localparam int SRRC_TX_TAPS     = 115;

endpackage

// File: rtl/srrc_tx_sequencer_clk_en_gen.sv
// -----------------------------------------------------------------------------
// clk_en_gen
// Divides the system clock into a one-clk sample strobe and a one-clk symbol
// strobe (coincident with the last sample strobe of each symbol). Shared with
// the receive side, which also consumes the sample phase.
//   clk          : system clock
//   i_rst_n      : asynchronous active-low reset
//   o_sam_clk_en : sample strobe, every CLKS_PER_SAM clocks
//   o_sym_clk_en : symbol strobe, every CLKS_PER_SAM*SAMS_PER_SYM clocks
//   o_sam_phase  : index of the current sample within the symbol
// -----------------------------------------------------------------------------
module clk_en_gen #(
    parameter  int CLKS_PER_SAM = 4,
    parameter  int SAMS_PER_SYM = 4,
    localparam int CW = $clog2(CLKS_PER_SAM),
    localparam int PW = $clog2(SAMS_PER_SYM)
) (
    input  logic          clk,
    input  logic          i_rst_n,
    output logic          o_sam_clk_en,
    output logic          o_sym_clk_en,
    output logic [PW-1:0] o_sam_phase
);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_SAM - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(SAMS_PER_SYM - 1);

    logic [CW-1:0] r_clk_cnt;
    logic [PW-1:0] r_sam_phase;
    logic          r_sam_clk_en;
    logic          w_cnt_last;

    assign w_cnt_last = (r_clk_cnt == CNT_LAST);

    // The strobe is a registered decode of the last count, so the first
    // pulse lands CLKS_PER_SAM clocks after reset release. The phase moves
    // after each strobe, so during a strobe it names that strobe's slot.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_cnt    <= '0;
            r_sam_clk_en <= 1'b0;
            r_sam_phase  <= '0;
        end else begin
            r_clk_cnt    <= w_cnt_last ? '0 : r_clk_cnt + CW'(1);
            r_sam_clk_en <= w_cnt_last;
            if (r_sam_clk_en)
                r_sam_phase <= (r_sam_phase == PH_LAST) ? '0 : r_sam_phase + PW'(1);
        end
    end

    assign o_sam_clk_en = r_sam_clk_en;
    assign o_sym_clk_en = r_sam_clk_en && (r_sam_phase == PH_LAST);
    assign o_sam_phase  = r_sam_phase;

endmodule

// File: rtl/srrc_tx_sequencer.sv
// -----------------------------------------------------------------------------
// srrc_tx_sequencer
// Drives the SRRC transmit filter: generates its sample/symbol strobes, pulls
// 4-ASK symbols over valid/ready, zero-stuffs them to the sample rate and
// flushes the filter with zeros before going idle.
//   clk, reset         : system clock, asynchronous active-low reset
//   enable             : level request to transmit
//   sym_in/sym_valid   : symbol source (held until transfer)
//   sym_ready          : symbol consumed this cycle
//   sam_clk_en         : one-clk sample strobe to filter
//   sym_clk_en         : one-clk symbol strobe to filter
//   flt_in             : zero-stuffed symbol stream to filter
//   busy               : RUN or FLUSH
//   underrun           : one-clk pulse, symbol slot starved in RUN
//   underrun_cnt       : saturating underrun count
// -----------------------------------------------------------------------------
module srrc_tx_sequencer
    import srrc_tx_sequencer_pkg::*;
#(
    parameter int CLKS_PER_SAM = CLKS_PER_SAM_DEF,
    parameter int SAMS_PER_SYM = SAMS_PER_SYM_DEF,
    parameter int FLT_TAPS     = SRRC_TX_TAPS,
    parameter int UCNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [SYM_W-1:0]  sym_in,
    input  logic              sym_valid,
    output logic              sym_ready,
    output logic              sam_clk_en,
    output logic              sym_clk_en,
    output logic [SYM_W-1:0]  flt_in,
    output logic              busy,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_cnt
);

    // Zeros must cover the delay line plus the adder and output registers.
    localparam int FLUSH_THR = FLT_TAPS + 2;
    localparam int FW        = $clog2(FLUSH_THR + 1);
    localparam int PW        = $clog2(SAMS_PER_SYM);

    txseq_state_e      r_state, w_next;
    logic [FW-1:0]     r_flush_cnt;
    logic [SYM_W-1:0]  r_flt_in;
    logic              r_busy;
    logic              r_underrun;
    logic [UCNT_W-1:0] r_ucnt;

    logic              w_sam, w_sym, w_ready, w_xfer, w_underrun, w_flush_done;
    logic [PW-1:0]     w_unused_sam_phase;  // only the receive side needs it

    clk_en_gen #(
        .CLKS_PER_SAM (CLKS_PER_SAM),
        .SAMS_PER_SYM (SAMS_PER_SYM)
    ) u_clk_en_gen (
        .clk          (clk),
        .i_rst_n      (reset),
        .o_sam_clk_en (w_sam),
        .o_sym_clk_en (w_sym),
        .o_sam_phase  (w_unused_sam_phase)
    );

    assign w_ready      = w_sym && (r_state == TXSEQ_RUN);
    assign w_xfer       = w_ready && sym_valid;
    assign w_underrun   = w_ready && !sym_valid;
    assign w_flush_done = (r_flush_cnt >= FW'(FLUSH_THR));

    // Transitions only at symbol boundaries keep every symbol on phase 0.
    always_comb begin
        w_next = r_state;
        if (w_sym) begin
            case (r_state)
                TXSEQ_IDLE:  if (enable) w_next = TXSEQ_RUN;
                TXSEQ_RUN:   if (!enable) w_next = TXSEQ_FLUSH;
                TXSEQ_FLUSH: begin
                    if (enable)
                        w_next = TXSEQ_RUN;
                    else if (w_flush_done)
                        w_next = TXSEQ_IDLE;
                end
                default:     w_next = TXSEQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= TXSEQ_IDLE;
            r_flush_cnt <= '0;
            r_flt_in    <= '0;
            r_busy      <= 1'b0;
            r_underrun  <= 1'b0;
            r_ucnt      <= '0;
        end else begin
            r_state    <= w_next;
            r_busy     <= (w_next != TXSEQ_IDLE);
            r_underrun <= w_underrun;
            if (w_underrun && (r_ucnt != '1))
                r_ucnt <= r_ucnt + UCNT_W'(1);
            // Counts sample strobes spent in FLUSH; any other state clears it,
            // so a FLUSH->RUN->FLUSH sequence restarts the drain.
            if (r_state != TXSEQ_FLUSH)
                r_flush_cnt <= '0;
            else if (w_sam && !w_flush_done)
                r_flush_cnt <= r_flush_cnt + FW'(1);
            // Symbol on its boundary strobe, zeros on the other strobes.
            if (w_sam)
                r_flt_in <= w_xfer ? sym_in : '0;
        end
    end

    assign sym_ready    = w_ready;
    assign sam_clk_en   = w_sam;
    assign sym_clk_en   = w_sym;
    assign flt_in       = r_flt_in;
    assign busy         = r_busy;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_ucnt;

endmodule

// File: tb/tb_srrc_tx_sequencer.sv
module tb_srrc_tx_sequencer;
    import srrc_tx_sequencer_pkg::*;

    localparam int CPS  = 4;
    localparam int SPS  = 4;
    localparam int TAPS = 115;
    localparam int UW   = 4;
    localparam int PER  = CPS * SPS;
    localparam int THR  = TAPS + 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic [SYM_W-1:0] sym_in = '0;
    logic             sym_valid = 1'b0;
    logic             sym_ready, sam_clk_en, sym_clk_en, busy, underrun;
    logic [SYM_W-1:0] flt_in;
    logic [UW-1:0]    underrun_cnt;

    srrc_tx_sequencer #(
        .CLKS_PER_SAM (CPS),
        .SAMS_PER_SYM (SPS),
        .FLT_TAPS     (TAPS),
        .UCNT_W       (UW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sym_in       (sym_in),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sam_clk_en   (sam_clk_en),
        .sym_clk_en   (sym_clk_en),
        .flt_in       (flt_in),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int               vecs = 0;
    int               errs = 0;
    // reference model state
    int               t;        // clock edges since reset release
    txseq_state_e     ms;
    int               fcnt;
    logic [UW-1:0]    e_ucnt;
    logic             e_und;
    logic [SYM_W-1:0] e_flt;
    logic [SYM_W-1:0] sbq[$];
    bit               sym_edge;
    logic [SYM_W-1:0] pat[4];
    int               idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0; ms = TXSEQ_IDLE; fcnt = 0; e_ucnt = '0; e_und = 1'b0; e_flt = '0;
        sbq.delete();
    endtask

    task automatic check_all();
        bit es, ey;
        es = (t >= CPS) && (t % CPS == 0);
        ey = (t >= PER) && (t % PER == 0);
        chk("sam_clk_en",   sam_clk_en,   es);
        chk("sym_clk_en",   sym_clk_en,   ey);
        chk("sym_ready",    sym_ready,    ey && (ms == TXSEQ_RUN));
        chk("busy",         busy,         ms != TXSEQ_IDLE);
        chk("underrun",     underrun,     e_und);
        chk("underrun_cnt", underrun_cnt, e_ucnt);
        chk("flt_in",       flt_in,       e_flt);
    endtask

    // One clock: predict the effect of the current inputs, step, then compare.
    task automatic cyc();
        bit es, ey, nu, xfer;
        txseq_state_e nx;
        es   = (t >= CPS) && (t % CPS == 0);
        ey   = (t >= PER) && (t % PER == 0);
        xfer = ey && (ms == TXSEQ_RUN) && sym_valid;
        nu   = ey && (ms == TXSEQ_RUN) && !sym_valid;
        if (es) sbq.push_back(xfer ? sym_in : '0);
        nx = ms;
        if (ey) begin
            case (ms)
                TXSEQ_IDLE:  if (enable) nx = TXSEQ_RUN;
                TXSEQ_RUN:   if (!enable) nx = TXSEQ_FLUSH;
                TXSEQ_FLUSH: if (enable) nx = TXSEQ_RUN; else if (fcnt >= THR) nx = TXSEQ_IDLE;
                default:     nx = TXSEQ_IDLE;
            endcase
        end
        if (ms != TXSEQ_FLUSH) fcnt = 0;
        else if (es && fcnt < THR) fcnt++;
        ms = nx;
        sym_edge = ey;
        @(posedge clk); #1;
        t++;
        e_und = nu;
        if (nu && e_ucnt != '1) e_ucnt++;
        if (es && sbq.size() > 0) e_flt = sbq.pop_front();
        if (xfer) begin
            idx++;
            sym_in = pat[idx % 4];
        end
        check_all();
    endtask

    // Run through the next symbol boundary with the given source valid level.
    task automatic slot(input bit v);
        sym_valid = v;
        do cyc(); while (!sym_edge);
    endtask

    initial begin
        pat[0] = SYMBOL_P2; pat[1] = SYMBOL_N1; pat[2] = SYMBOL_P1; pat[3] = SYMBOL_N2;
        idx = 0;
        model_reset();
        #2 check_all();
        repeat (3) begin @(posedge clk); #1; check_all(); end
        reset = 1'b1;

        // strobes only, idle
        repeat (200) cyc();

        // enable mid-symbol, stream with two starved slots
        while (t % PER != 7) cyc();
        enable = 1'b1; sym_in = pat[0];
        slot(1'b1);
        chk("busy_after_start", busy, 1);
        slot(1'b1); slot(1'b1); slot(1'b0); slot(1'b0);
        chk("ucnt_two", underrun_cnt, 2);
        repeat (6) slot(1'b1);

        // flush, re-enable mid-flush, then full drain to idle
        enable = 1'b0; slot(1'b1);
        repeat (20) slot(1'b1);
        enable = 1'b1; slot(1'b1);
        chk("busy_reenter", busy, 1);
        slot(1'b1); slot(1'b1);
        enable = 1'b0; slot(1'b1);
        repeat (29) slot(1'b1);
        chk("busy_flush_29", busy, 1);
        slot(1'b1);
        chk("busy_idle_30", busy, 0);
        repeat (3) slot(1'b1);

        // asynchronous reset between strobes while running
        enable = 1'b1; slot(1'b1); slot(1'b1);
        repeat (5) cyc();
        #2 reset = 1'b0;
        #1 model_reset();
        check_all();
        repeat (2) begin @(posedge clk); #1; check_all(); end
        reset = 1'b1; enable = 1'b0; sym_valid = 1'b0;
        repeat (20) cyc();

        // underrun counter saturation
        enable = 1'b1; slot(1'b0);
        repeat (20) slot(1'b0);
        chk("ucnt_sat", underrun_cnt, 15);
        chk("sb_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/srrc_tx_sequencer.md
Name: srrc_tx_sequencer

Overview:
- Sequences the practical SRRC transmit filter.
- Generates the filter's sam_clk_en and sym_clk_en strobes from the system clock.
- Pulls 4-ASK symbols from an upstream source over a valid/ready handshake and zero-stuffs them to the sample rate on the filter input.
- Manages start-up and a flush phase, so the filter pipeline drains to zero before going idle.

Parameters:
CLKS_PER_SAM, 4, system clocks per sample strobe (>=2)
SAMS_PER_SYM, 4, samples per symbol (upsampling factor, >=2)
FLT_TAPS, 115, filter delay-line length; sets flush duration
UCNT_W, 16, width of underrun counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
enable  in  1  level request to transmit
sym_in  in  18  symbol from source; legal values `SYMBOL_P2/P1/N1/N2
sym_valid  in  1  source has a symbol
sym_ready  out  1  symbol consumed this cycle
sam_clk_en  out  1  one-clk sample strobe to filter
sym_clk_en  out  1  one-clk symbol strobe to filter
flt_in  out  18  zero-stuffed symbol stream to filter input
busy  out  1  state is RUN or FLUSH
underrun  out  1  one-clk pulse: symbol slot with no valid symbol in RUN
underrun_cnt  out  UCNT_W  saturating count of underruns

Behaviour:
- Reset (reset==0, async): all counters 0, state IDLE. All outputs 0: flt_in, sym_ready, strobes, busy, underrun, underrun_cnt.
- clk_cnt: runs 0..CLKS_PER_SAM-1 and wraps; free-running in every state.
- sam_clk_en: 1 exactly when clk_cnt==CLKS_PER_SAM-1; registered output. The first pulse occurs CLKS_PER_SAM clocks after reset release.
- sam_phase: runs 0..SAMS_PER_SYM-1 and advances on sam_clk_en.
- sym_clk_en: sam_clk_en && sam_phase==SAMS_PER_SYM-1, coincident with that sam_clk_en. Period = CLKS_PER_SAM*SAMS_PER_SYM clocks (16 by default).
- FSM states: IDLE, RUN, FLUSH. All transitions are taken only on a sym_clk_en cycle, so symbols stay aligned to sam_phase 0.
  - IDLE -> RUN: enable==1.
  - RUN -> FLUSH: enable==0.
  - FLUSH -> RUN: enable==1; flush counter cleared.
  - FLUSH -> IDLE: flush_cnt >= FLT_TAPS+2 sample strobes and enable==0. flush_cnt is evaluated at the sym_clk_en boundary; the count covers the delay line, the adder register and the output register.
  - enable changes between strobes have no effect until the next sym_clk_en.
- Handshake:
  - sym_ready = sym_clk_en && state==RUN (combinational from registered terms); it is never high outside RUN.
  - Transfer occurs when sym_ready && sym_valid. The source must hold sym_valid/sym_in until transfer.
- flt_in (registered, updated only on a sam_clk_en cycle, held otherwise):
  - On a sym_clk_en cycle: flt_in <= (state==RUN && sym_valid) ? sym_in : 0. The state used is the pre-transition value.
  - On any other sam_clk_en: flt_in <= 0 (zero-stuffing).
  - The filter therefore sees one symbol followed by SAMS_PER_SYM-1 zeros.
- Underrun:
  - Condition: state==RUN && sym_clk_en && !sym_valid.
  - Effect: underrun=1 for one clk, flt_in <= 0, and underrun_cnt increments.
  - underrun_cnt saturates at all-ones and clears only on reset.
- busy: registered; 1 in RUN and FLUSH.
- Illegal sym_in values are passed through unchanged; the filter maps them to zero.
- Mid-operation reset: immediate return to the reset values above, with no flush.

Decomposition:
- Shared defines.vh holds:
  - `SYMBOL_P2/P1/N1/N2 (already present).
  - State encodings `TXSEQ_IDLE=2'd0, `TXSEQ_RUN=2'd1, `TXSEQ_FLUSH=2'd2.
  - Defaults `CLKS_PER_SAM, `SAMS_PER_SYM, `SRRC_TX_TAPS.
- One sub-module, clk_en_gen: the clk_cnt/sam_phase dividers producing sam_clk_en, sym_clk_en and sam_phase. It is reusable by the receive side.
- FSM, handshake, zero-stuffing and underrun logic stay in srrc_tx_sequencer.

Test Plan:
- Strobe timing: release reset, enable=0, run 200 clks -> sam_clk_en every 4 clks (first at clk 4), sym_clk_en every 16 clks coincident with every 4th sam_clk_en, flt_in==0, busy==0, sym_ready never 1.
- Start and stream: raise enable mid-symbol; source always valid with sequence P2,N1,P1,N2 -> busy rises at next sym_clk_en; each symbol accepted on a sym_ready pulse; flt_in shows sym,0,0,0 per symbol, each value held 4 clks.
- Underrun: drop sym_valid for symbol slots 3 and 4 in RUN -> two underrun pulses, flt_in 0 in those slots, underrun_cnt==2, stream resumes on slot 5 with no phase slip.
- Flush: drop enable after 10 symbols -> FLUSH at next sym_clk_en, flt_in all zero, IDLE after >=117 sample strobes (first symbol boundary at or after), busy falls; re-enable during FLUSH -> returns to RUN at next sym_clk_en with flush_cnt cleared.
- Reset mid-run: assert reset (0) during RUN between strobes -> all outputs 0 asynchronously; after release, first sam_clk_en 4 clks later, state IDLE.
- Saturation: with UCNT_W=4, force 20 underruns -> underrun_cnt stops at 15, underrun still pulses each slot.
